// File: rtl/mips_dmem_mmio.sv
// Data-side memory responder: word RAM plus a small MMIO block.
// The MMIO block holds a cycle counter, a one-shot timer with an IRQ flag and a transmit FIFO.
// Ports:
//   clk, reset (async, active-low)
//   memwrite, addr, writedata, readdata: core memory-stage access
//   out_valid, out_data, out_ready: FIFO drain handshake
//   irq: timer_done flag
module mips_dmem_mmio #(
    parameter int DEPTH      = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready,
    output logic        irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [31:0]   ram [DEPTH];
    logic [31:0]   fifoMem [FIFO_DEPTH];
    logic [PW-1:0] rdPtr, wrPtr;
    logic [PW:0]   count;
    logic [31:0]   cycleCnt, timerVal;
    logic          timerDone, overflow;

    logic          isMmio;
    logic [3:0]    regSel;
    logic [AW-1:0] wordIdx;
    logic          ramWr, wrTimer, wrStatus, wrTx;
    logic          fifoEmpty, fifoFull;
    logic          push, pop, ovfSet, expire;
    logic [4:0]    count5;
    logic [31:0]   statusWord;
    logic          unusedBits;

    assign isMmio  = addr[31];
    assign regSel  = addr[5:2];
    assign wordIdx = addr[AW+1:2];

    assign ramWr    = memwrite && !isMmio;
    assign wrTimer  = memwrite && isMmio && (regSel == 4'h1);
    assign wrStatus = memwrite && isMmio && (regSel == 4'h2);
    assign wrTx     = memwrite && isMmio && (regSel == 4'h3);

    assign fifoEmpty = (count == '0);
    assign fifoFull  = (count == (PW+1)'(FIFO_DEPTH));

    // A pop frees the head slot in the same edge, so a push while full
    // is accepted when the consumer is draining.
    assign pop    = !fifoEmpty && out_ready;
    assign push   = wrTx && (!fifoFull || pop);
    assign ovfSet = wrTx && fifoFull && !pop;
    assign expire = !wrTimer && (timerVal == 32'd1);

    assign count5     = 5'(count);
    assign statusWord = {23'd0, count5, fifoFull, fifoEmpty,
                         overflow, timerDone};

    assign out_valid = !fifoEmpty;
    assign out_data  = fifoMem[rdPtr];
    assign irq       = timerDone;

    assign unusedBits = ^{addr[30:6], addr[1:0]};

    always_comb begin
        readdata = 32'd0;
        if (!isMmio) begin
            readdata = ram[wordIdx];
        end else begin
            case (regSel)
                4'h0:    readdata = cycleCnt;
                4'h1:    readdata = timerVal;
                4'h2:    readdata = statusWord;
                default: readdata = 32'd0;
            endcase
        end
    end

    // Storage arrays carry no reset; validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (ramWr) begin
            ram[wordIdx] <= writedata;
        end
        if (push) begin
            fifoMem[wrPtr] <= writedata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycleCnt  <= 32'd0;
            timerVal  <= 32'd0;
            timerDone <= 1'b0;
            overflow  <= 1'b0;
            rdPtr     <= '0;
            wrPtr     <= '0;
            count     <= '0;
        end else begin
            cycleCnt <= cycleCnt + 32'd1;

            if (wrTimer) begin
                timerVal <= writedata;
            end else if (timerVal != 32'd0) begin
                timerVal <= timerVal - 32'd1;
            end

            // Setting beats a same-cycle W1C.
            if (expire) begin
                timerDone <= 1'b1;
            end else if (wrStatus && writedata[0]) begin
                timerDone <= 1'b0;
            end

            if (ovfSet) begin
                overflow <= 1'b1;
            end else if (wrStatus && writedata[1]) begin
                overflow <= 1'b0;
            end

            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

endmodule

// File: tb/tb_mips_dmem_mmio.sv
// Self-checking bench for mips_dmem_mmio: directed scenarios plus
// randomized traffic checked against a queue/array reference model.
module tb_mips_dmem_mmio;

    localparam int DEPTH = 64;
    localparam int FD    = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        irq;

    mips_dmem_mmio #(.DEPTH(DEPTH), .FIFO_DEPTH(FD)) dut (
        .clk(clk),
        .reset(reset),
        .memwrite(memwrite),
        .addr(addr),
        .writedata(writedata),
        .readdata(readdata),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .irq(irq)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass   = 0;

    // reference model state
    logic [31:0] ramM [DEPTH];
    bit          known [DEPTH];
    logic [31:0] q [$];
    logic [31:0] cycleM;
    logic [31:0] timerM;
    bit          doneM;
    bit          ovfM;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nChecks++;
        if (got === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void resetModel();
        cycleM = 0;
        timerM = 0;
        doneM  = 0;
        ovfM   = 0;
        q.delete();
    endfunction

    function automatic logic [31:0] statusM();
        int n = q.size();
        return 32'(doneM) | (32'(ovfM) << 1) | (32'(n == 0) << 2)
             | (32'(n == FD) << 3) | (32'(n) << 4);
    endfunction

    function automatic void expRead(input logic [31:0] a,
                                    output logic [31:0] v, output bit ok);
        int idx;
        int off;
        ok = 1;
        v  = 0;
        if (a < 32'h8000_0000) begin
            idx = int'((a / 4) % DEPTH);
            ok  = known[idx];
            v   = ramM[idx];
        end else begin
            off = int'((a / 4) % 16);
            if (off == 0) v = cycleM;
            else if (off == 1) v = timerM;
            else if (off == 2) v = statusM();
        end
    endfunction

    // One clock cycle: drive at negedge, check combinational outputs,
    // then advance the model across the rising edge.
    task automatic cyc(input bit we, input logic [31:0] a,
                       input logic [31:0] wd, input bit rdy);
        logic [31:0] ev;
        bit          ok;
        bit          mmio;
        int          off;
        bit          pop;
        bit          full;
        bit          exp1;
        memwrite  = we;
        addr      = a;
        writedata = wd;
        out_ready = rdy;
        #1;
        expRead(a, ev, ok);
        if (ok) chk("readdata", readdata, ev);
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0) chk("out_data", out_data, q[0]);
        chk("irq", 32'(irq), 32'(doneM));
        @(posedge clk);
        mmio = a[31];
        off  = int'((a / 4) % 16);
        if (we && !mmio) begin
            ramM[(a / 4) % DEPTH]  = wd;
            known[(a / 4) % DEPTH] = 1;
        end
        full = (q.size() == FD);
        pop  = (q.size() > 0) && rdy;
        if (pop) void'(q.pop_front());
        if (we && mmio && off == 3) begin
            if (!full || pop) q.push_back(wd);
            else ovfM = 1;
        end else if (we && mmio && off == 2 && wd[1]) begin
            ovfM = 0;
        end
        exp1 = 0;
        if (we && mmio && off == 1) begin
            timerM = wd;
        end else if (timerM != 0) begin
            exp1   = (timerM == 1);
            timerM = timerM - 1;
        end
        if (exp1) doneM = 1;
        else if (we && mmio && off == 2 && wd[0]) doneM = 0;
        cycleM = cycleM + 1;
        @(negedge clk);
    endtask

    task automatic idle(input logic [31:0] a, input bit rdy, input int n);
        for (int i = 0; i < n; i++) cyc(0, a, 0, rdy);
    endtask

    localparam logic [31:0] CYC = 32'h8000_0000;
    localparam logic [31:0] TMR = 32'h8000_0004;
    localparam logic [31:0] STS = 32'h8000_0008;
    localparam logic [31:0] TXD = 32'h8000_000C;

    initial begin
        logic [31:0] a;
        logic [31:0] wd;
        reset     = 1'b0;
        memwrite  = 1'b0;
        addr      = STS;
        writedata = 0;
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) known[i] = 0;
        resetModel();
        repeat (2) @(negedge clk);
        chk("rst_status", readdata, 32'h4);
        chk("rst_valid", 32'(out_valid), 0);
        reset = 1'b1;

        // cycle counter 0 then 5
        addr = CYC;
        #1;
        chk("cycle0", readdata, 0);
        idle(CYC, 0, 6);
        idle(STS, 0, 1);

        // RAM and alias
        cyc(1, 32'h10, 32'hDEAD_BEEF, 0);
        cyc(0, 32'h10, 0, 0);
        cyc(0, 32'h110, 0, 0);
        chk("alias", readdata, 32'hDEAD_BEEF);

        // timer expiry and W1C
        cyc(1, TMR, 3, 0);
        idle(TMR, 0, 4);
        cyc(1, STS, 1, 0);
        idle(STS, 0, 1);
        // W1C on the expiry cycle
        cyc(1, TMR, 2, 0);
        idle(TMR, 0, 1);
        cyc(1, STS, 1, 0);
        idle(STS, 0, 1);
        chk("w1c_vs_expire", 32'(irq), 1);
        cyc(1, STS, 1, 0);

        // FIFO fill, overflow, drain
        cyc(1, TXD, 32'h11, 0);
        cyc(1, TXD, 32'h22, 0);
        cyc(1, TXD, 32'h33, 0);
        cyc(1, TXD, 32'h44, 0);
        idle(STS, 0, 1);
        cyc(1, TXD, 32'h55, 0);
        idle(STS, 0, 1);
        chk("full_ovf", readdata, 32'h4A);
        idle(STS, 1, 5);
        cyc(1, STS, 2, 0);

        // push and pop while full
        cyc(1, TXD, 32'h11, 0);
        cyc(1, TXD, 32'h22, 0);
        cyc(1, TXD, 32'h33, 0);
        cyc(1, TXD, 32'h44, 0);
        cyc(1, TXD, 32'h66, 1);
        idle(STS, 1, 5);

        // reset mid-operation
        cyc(1, TMR, 100, 0);
        cyc(1, TXD, 32'hA1, 0);
        cyc(1, TXD, 32'hA2, 0);
        addr     = STS;
        memwrite = 0;
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_irq", 32'(irq), 0);
        chk("midrst_status", readdata, 32'h4);
        resetModel();
        @(negedge clk);
        reset = 1'b1;
        idle(STS, 0, 2);
        idle(TMR, 0, 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                a = {1'b0, 31'($urandom)};
            end else begin
                a = {1'b1, 25'($urandom), 4'($urandom_range(0, 7)),
                     2'($urandom)};
            end
            wd = $urandom;
            if (a[31] && a[5:2] == 4'h1) wd = $urandom_range(0, 12);
            cyc($urandom_range(0, 9) < 4, a, wd, $urandom_range(0, 3) == 0);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
